param_cache: RTL and testbench

PARAM_CACHE -- requirements
Module: param_cache

---
 rtl/param_cache.sv | 138 +++++++++++++
 tb/tb_param_cache.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_cache.sv
// Direct-mapped, write-through cache: any miss fills the whole line from memory,
// after which the held request completes as an ordinary hit.
module param_cache #(
  parameter int ADDR_W   = 16,
  parameter int WORD_W   = 16,
  parameter int INDEX_W  = 7,
  parameter int OFFSET_W = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic              i_inv_all,
  output logic [WORD_W-1:0] o_rdata,
  output logic              o_hit,
  output logic              o_stall,
  output logic              o_mem_rd,
  output logic              o_mem_wr,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [WORD_W-1:0] o_mem_wdata,
  input  logic [WORD_W-1:0] i_mem_rdata,
  input  logic              i_mem_rvalid
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W - 1;
  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;

  typedef enum logic [1:0] {IDLE, FILL, FINISH} state_t;

  state_t              r_state;
  logic [OFFSET_W:0]   r_issue_cnt;
  logic [OFFSET_W-1:0] r_resp_cnt;
  logic [ADDR_W-1:0]   r_base;
  logic [LINES-1:0]    r_valid;
  logic [TAG_W-1:0]    r_tag  [LINES];
  logic [WORD_W-1:0]   r_data [LINES][WORDS];

  logic [OFFSET_W-1:0] w_offset;
  logic [INDEX_W-1:0]  w_index;
  logic [TAG_W-1:0]    w_tag;
  logic [INDEX_W-1:0]  w_fill_index;
  logic [TAG_W-1:0]    w_fill_tag;
  logic                w_idle;
  logic                w_lookup;
  logic                w_hit;
  logic                w_wr_hit;
  logic                w_miss;
  logic                w_issue;
  logic                w_resp;
  logic                w_unused_addr0;

  assign w_offset       = i_addr[OFFSET_W:1];
  assign w_index        = i_addr[OFFSET_W+INDEX_W:OFFSET_W+1];
  assign w_tag          = i_addr[ADDR_W-1:OFFSET_W+INDEX_W+1];
  assign w_fill_index   = r_base[OFFSET_W+INDEX_W:OFFSET_W+1];
  assign w_fill_tag     = r_base[ADDR_W-1:OFFSET_W+INDEX_W+1];
  assign w_unused_addr0 = i_addr[0];

  // inv_all with req suppresses the hit and any write; the request retries next cycle.
  assign w_idle   = (r_state == IDLE) & i_rst_n;
  assign w_lookup = i_req & ~i_inv_all & r_valid[w_index] & (r_tag[w_index] == w_tag);
  assign w_hit    = w_idle & w_lookup;
  assign w_wr_hit = w_hit & i_we;
  assign w_miss   = w_idle & i_req & ~i_inv_all & ~w_lookup;
  assign w_issue  = (r_state == FILL) & ~r_issue_cnt[OFFSET_W] & i_rst_n;
  assign w_resp   = (r_state == FILL) & i_mem_rvalid;

  always_comb begin
    o_hit       = w_hit;
    o_rdata     = w_hit ? r_data[w_index][w_offset] : '0;
    o_stall     = i_rst_n & ((r_state != IDLE) | (i_req & ~w_hit));
    o_mem_rd    = w_issue;
    o_mem_wr    = w_wr_hit;
    o_mem_wdata = w_wr_hit ? i_wdata : '0;
    o_mem_addr  = '0;
    if (w_wr_hit) begin
      o_mem_addr = {i_addr[ADDR_W-1:1], 1'b0};
    end else if (w_issue) begin
      o_mem_addr = r_base + (ADDR_W'(r_issue_cnt) << 1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_issue_cnt <= '0;
      r_resp_cnt  <= '0;
      r_base      <= '0;
      r_valid     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_inv_all) begin
            r_valid <= '0;
          end else if (w_miss) begin
            r_base      <= {i_addr[ADDR_W-1:OFFSET_W+1], {(OFFSET_W+1){1'b0}}};
            r_issue_cnt <= '0;
            r_resp_cnt  <= '0;
            r_state     <= FILL;
          end
        end
        FILL: begin
          if (w_issue) begin
            r_issue_cnt <= r_issue_cnt + 1'b1;
          end
          if (i_mem_rvalid) begin
            r_resp_cnt <= r_resp_cnt + 1'b1;
            if (&r_resp_cnt) begin
              r_state <= FINISH;
            end
          end
        end
        FINISH: begin
          r_valid[w_fill_index] <= 1'b1;
          r_state               <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Tag and data storage carries no reset; the valid bits alone guard it.
  always_ff @(posedge i_clk) begin
    if (w_wr_hit) begin
      r_data[w_index][w_offset] <= i_wdata;
    end
    if (w_resp) begin
      r_data[w_fill_index][r_resp_cnt] <= i_mem_rdata;
    end
    if (r_state == FINISH) begin
      r_tag[w_fill_index] <= w_fill_tag;
    end
  end

endmodule

// File: tb/tb_param_cache.sv
// Self-checking bench for param_cache: a word-addressed memory model serves fills,
// and a line-residency model predicts hits while memory contents predict read data.
module tb_param_cache;

  logic        clk = 1'b0;
  logic        rst_n, req, we, inv_all, mem_rvalid;
  logic [15:0] addr, wdata, mem_rdata;
  logic [15:0] rdata, mem_addr, mem_wdata;
  logic        hit, stall, mem_rd, mem_wr;

  int testsRun = 0;
  int testsFailed = 0;
  int cyc = 0;
  int fixedLat = 0;
  int respCount = 0;
  int rspLat, rspRdy;

  logic [15:0] memModel [0:32767];
  logic        expValid [0:127];
  logic [4:0]  expTag   [0:127];

  typedef struct {
    logic [15:0] data;
    int          ready;
  } resp_t;
  resp_t       respQ[$];
  logic [15:0] rdLogAddr[$];
  int          rdLogCyc[$];

  param_cache dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_addr(addr),
    .i_wdata(wdata), .i_inv_all(inv_all), .o_rdata(rdata), .o_hit(hit),
    .o_stall(stall), .o_mem_rd(mem_rd), .o_mem_wr(mem_wr), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .i_mem_rvalid(mem_rvalid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: accepts one word request per cycle, answers in order after >= 1 cycle.
  always @(negedge clk) begin
    #2;
    if (mem_rd === 1'b1) begin
      rspLat = (fixedLat > 0) ? fixedLat : int'($urandom_range(4, 1));
      rspRdy = cyc + rspLat;
      if (respQ.size() > 0 && rspRdy <= respQ[$].ready) rspRdy = respQ[$].ready + 1;
      respQ.push_back('{memModel[mem_addr[15:1]], rspRdy});
      rdLogAddr.push_back(mem_addr);
      rdLogCyc.push_back(cyc);
    end
    if (respQ.size() > 0 && respQ[0].ready <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = respQ[0].data;
      void'(respQ.pop_front());
      respCount++;
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = 16'($urandom);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [6:0] idxOf(input logic [15:0] a);
    return a[10:4];
  endfunction

  function automatic logic [4:0] tagOf(input logic [15:0] a);
    return a[15:11];
  endfunction

  function automatic void clearModel();
    for (int i = 0; i < 128; i++) expValid[i] = 1'b0;
  endfunction

  function automatic void markResident(input logic [15:0] a);
    expValid[idxOf(a)] = 1'b1;
    expTag[idxOf(a)]   = tagOf(a);
  endfunction

  // Presents one access and holds it until the cache reports a hit.
  task automatic cpu_access(input logic w, input logic [15:0] a, input logic [15:0] d,
                            output logic fHit, output logic fStall, output int lat,
                            output logic [15:0] rd, output logic wr,
                            output logic [15:0] wAddr, output logic [15:0] wDat,
                            output logic tmo);
    int start;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d; inv_all = 1'b0;
    #1;
    fHit = hit; fStall = stall; start = cyc; tmo = 1'b0;
    while (hit !== 1'b1 && !tmo) begin
      @(negedge clk);
      #1;
      if (cyc - start > 300) tmo = 1'b1;
    end
    lat = cyc - start; rd = rdata; wr = mem_wr; wAddr = mem_addr; wDat = mem_wdata;
    @(negedge clk);
    req = 1'b0; we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b1; we = 1'b1; addr = 16'h1234; wdata = 16'h5555; inv_all = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    testsRun++; if (hit !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_hit: got %b want 0", hit); end
    testsRun++; if (stall !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_stall: got %b want 0", stall); end
    testsRun++; if (mem_rd !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_mem_rd: got %b want 0", mem_rd); end
    testsRun++; if (mem_wr !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_mem_wr: got %b want 0", mem_wr); end
    testsRun++; if (mem_addr !== 16'h0) begin testsFailed++; $display("[TB] FAIL reset_mem_addr: got %h want 0000", mem_addr); end
    testsRun++; if (mem_wdata !== 16'h0) begin testsFailed++; $display("[TB] FAIL reset_mem_wdata: got %h want 0000", mem_wdata); end
    testsRun++; if (rdata !== 16'h0) begin testsFailed++; $display("[TB] FAIL reset_rdata: got %h want 0000", rdata); end
    req = 1'b0; we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clearModel();
  endtask

  task automatic test_read_miss();
    logic fHit, fStall, wr, tmo;
    logic [15:0] rd, wAddr, wDat;
    int lat;
    for (int i = 0; i < 8; i++) memModel[(16'h1230 >> 1) + i] = 16'hA000 + 16'(i);
    fixedLat = 3;
    rdLogAddr.delete(); rdLogCyc.delete();
    cpu_access(1'b0, 16'h1234, 16'h0, fHit, fStall, lat, rd, wr, wAddr, wDat, tmo);
    fixedLat = 0;
    testsRun++; if (tmo !== 1'b0) begin testsFailed++; $display("[TB] FAIL rmiss_timeout: got %b want 0", tmo); end
    testsRun++; if (fHit !== 1'b0) begin testsFailed++; $display("[TB] FAIL rmiss_first_hit: got %b want 0", fHit); end
    testsRun++; if (fStall !== 1'b1) begin testsFailed++; $display("[TB] FAIL rmiss_first_stall: got %b want 1", fStall); end
    testsRun++; if (lat !== 13) begin testsFailed++; $display("[TB] FAIL rmiss_latency: got %0d want 13", lat); end
    testsRun++; if (rd !== 16'hA002) begin testsFailed++; $display("[TB] FAIL rmiss_rdata: got %h want a002", rd); end
    testsRun++; if (rdLogAddr.size() !== 8) begin testsFailed++; $display("[TB] FAIL rmiss_rd_count: got %0d want 8", rdLogAddr.size()); end
    for (int i = 0; i < rdLogAddr.size(); i++) begin
      testsRun++;
      if (rdLogAddr[i] !== 16'h1230 + 16'(2 * i)) begin
        testsFailed++; $display("[TB] FAIL rmiss_fill_addr%0d: got %h want %h", i, rdLogAddr[i], 16'h1230 + 16'(2 * i));
      end
    end
    if (rdLogCyc.size() == 8) begin
      testsRun++; if (rdLogCyc[7] - rdLogCyc[0] !== 7) begin testsFailed++; $display("[TB] FAIL rmiss_rd_span: got %0d want 7", rdLogCyc[7] - rdLogCyc[0]); end
    end
    markResident(16'h1234);
  endtask

  task automatic test_write_hit();
    logic fHit, fStall, wr, tmo;
    logic [15:0] rd, wAddr, wDat;
    int lat;
    cpu_access(1'b1, 16'h1236, 16'hBEEF, fHit, fStall, lat, rd, wr, wAddr, wDat, tmo);
    testsRun++; if (fHit !== 1'b1) begin testsFailed++; $display("[TB] FAIL whit_hit: got %b want 1", fHit); end
    testsRun++; if (fStall !== 1'b0) begin testsFailed++; $display("[TB] FAIL whit_stall: got %b want 0", fStall); end
    testsRun++; if (wr !== 1'b1) begin testsFailed++; $display("[TB] FAIL whit_mem_wr: got %b want 1", wr); end
    testsRun++; if (wAddr !== 16'h1236) begin testsFailed++; $display("[TB] FAIL whit_mem_addr: got %h want 1236", wAddr); end
    testsRun++; if (wDat !== 16'hBEEF) begin testsFailed++; $display("[TB] FAIL whit_mem_wdata: got %h want beef", wDat); end
    memModel[16'h1236 >> 1] = 16'hBEEF;
    cpu_access(1'b0, 16'h1236, 16'h0, fHit, fStall, lat, rd, wr, wAddr, wDat, tmo);
    testsRun++; if (fHit !== 1'b1) begin testsFailed++; $display("[TB] FAIL whit_reread_hit: got %b want 1", fHit); end
    testsRun++; if (rd !== 16'hBEEF) begin testsFailed++; $display("[TB] FAIL whit_reread_data: got %h want beef", rd); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a, d;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a = 16'h1230 + 16'(2 * ((i * 3) % 8));
      req = 1'b1; we = 1'b0; addr = a; inv_all = 1'b0;
      #1;
      testsRun++; if (hit !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b_hit%0d: got %b want 1", i, hit); end
      testsRun++; if (rdata !== memModel[a[15:1]]) begin testsFailed++; $display("[TB] FAIL b2b_rdata%0d: got %h want %h", i, rdata, memModel[a[15:1]]); end
      testsRun++; if (mem_wr !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_mem_wr%0d: got %b want 0", i, mem_wr); end
    end
    d = 16'($urandom);
    @(negedge clk);
    we = 1'b1; addr = 16'h1232; wdata = d;
    #1;
    testsRun++; if (mem_wr !== 1'b1 || mem_wdata !== d) begin testsFailed++; $display("[TB] FAIL b2b_write: got wr=%b data=%h want wr=1 data=%h", mem_wr, mem_wdata, d); end
    memModel[16'h1232 >> 1] = d;
    @(negedge clk);
    we = 1'b0;
    #1;
    testsRun++; if (hit !== 1'b1 || rdata !== d) begin testsFailed++; $display("[TB] FAIL b2b_raw: got hit=%b data=%h want hit=1 data=%h", hit, rdata, d); end
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic test_write_miss();
    logic fHit, fStall, wr, tmo;
    logic [15:0] rd, wAddr, wDat, d;
    int lat;
    d = 16'($urandom);
    rdLogAddr.delete(); rdLogCyc.delete();
    cpu_access(1'b1, 16'h5678, d, fHit, fStall, lat, rd, wr, wAddr, wDat, tmo);
    testsRun++; if (tmo !== 1'b0) begin testsFailed++; $display("[TB] FAIL wmiss_timeout: got %b want 0", tmo); end
    testsRun++; if (fHit !== 1'b0 || fStall !== 1'b1) begin testsFailed++; $display("[TB] FAIL wmiss_first: got hit=%b stall=%b want hit=0 stall=1", fHit, fStall); end
    testsRun++; if (rdLogAddr.size() !== 8) begin testsFailed++; $display("[TB] FAIL wmiss_rd_count: got %0d want 8", rdLogAddr.size()); end
    if (rdLogAddr.size() > 0) begin
      testsRun++; if (rdLogAddr[0] !== 16'h5670) begin testsFailed++; $display("[TB] FAIL wmiss_base: got %h want 5670", rdLogAddr[0]); end
    end
    testsRun++; if (wr !== 1'b1 || wAddr !== 16'h5678 || wDat !== d) begin testsFailed++; $display("[TB] FAIL wmiss_writethrough: got wr=%b addr=%h data=%h want 1 5678 %h", wr, wAddr, wDat, d); end
    memModel[16'h5678 >> 1] = d;
    markResident(16'h5678);
    cpu_access(1'b0, 16'h567A, 16'h0, fHit, fStall, lat, rd, wr, wAddr, wDat, tmo);
    testsRun++; if (fHit !== 1'b1) begin testsFailed++; $display("[TB] FAIL wmiss_neighbour_hit: got %b want 1", fHit); end
    testsRun++; if (rd !== memModel[16'h567A >> 1]) begin testsFailed++; $display("[TB] FAIL wmiss_neighbour_data: got %h want %h", rd, memModel[16'h567A >> 1]); end
    cpu_access(1'b0, 16'h5678, 16'h0, fHit, fStall, lat, rd, wr, wAddr, wDat, tmo);
    testsRun++; if (rd !== d) begin testsFailed++; $display("[TB] FAIL wmiss_written_data: got %h want %h", rd, d); end
  endtask

  task automatic test_conflict();
    logic fHit, fStall, wr, tmo;
    logic [15:0] rd, wAddr, wDat;
    int lat;
    cpu_access(1'b0, 16'h0010, 16'h0, fHit, fStall, lat, rd, wr, wAddr, wDat, tmo);
    testsRun++; if (fHit !== 1'b0 || rd !== memModel[16'h0010 >> 1]) begin testsFailed++; $display("[TB] FAIL conf_first: got hit=%b data=%h want 0 %h", fHit, rd, memModel[16'h0010 >> 1]); end
    rdLogAddr.delete(); rdLogCyc.delete();
    cpu_access(1'b0, 16'h0810, 16'h0, fHit, fStall, lat, rd, wr, wAddr, wDat, tmo);
    testsRun++; if (fHit !== 1'b0) begin testsFailed++; $display("[TB] FAIL conf_evict_hit: got %b want 0", fHit); end
    testsRun++; if (rd !== memModel[16'h0810 >> 1]) begin testsFailed++; $display("[TB] FAIL conf_evict_data: got %h want %h", rd, memModel[16'h0810 >> 1]); end
    if (rdLogAddr.size() > 0) begin
      testsRun++; if (rdLogAddr[0] !== 16'h0810) begin testsFailed++; $display("[TB] FAIL conf_base: got %h want 0810", rdLogAddr[0]); end
    end
    cpu_access(1'b0, 16'h0010, 16'h0, fHit, fStall, lat, rd, wr, wAddr, wDat, tmo);
    testsRun++; if (fHit !== 1'b0 || rd !== memModel[16'h0010 >> 1]) begin testsFailed++; $display("[TB] FAIL conf_reread: got hit=%b data=%h want 0 %h", fHit, rd, memModel[16'h0010 >> 1]); end
    cpu_access(1'b0, 16'h0010, 16'h0, fHit, fStall, lat, rd, wr, wAddr, wDat, tmo);
    testsRun++; if (fHit !== 1'b1) begin testsFailed++; $display("[TB] FAIL conf_resident: got %b want 1", fHit); end
    markResident(16'h0010);
  endtask

  task automatic test_inv_all();
    logic fHit, fStall, wr, tmo;
    logic [15:0] rd, wAddr, wDat;
    int lat;
    cpu_access(1'b0, 16'h1234, 16'h0, fHit, fStall, lat, rd, wr, wAddr, wDat, tmo);
    testsRun++; if (fHit !== 1'b1) begin testsFailed++; $display("[TB] FAIL inv_pre_hit: got %b want 1", fHit); end
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 16'h1234; wdata = ~memModel[16'h1234 >> 1]; inv_all = 1'b1;
    #1;
    testsRun++; if (hit !== 1'b0) begin testsFailed++; $display("[TB] FAIL inv_hit: got %b want 0", hit); end
    testsRun++; if (stall !== 1'b1) begin testsFailed++; $display("[TB] FAIL inv_stall: got %b want 1", stall); end
    testsRun++; if (mem_wr !== 1'b0) begin testsFailed++; $display("[TB] FAIL inv_mem_wr: got %b want 0", mem_wr); end
    clearModel();
    cpu_access(1'b0, 16'h1234, 16'h0, fHit, fStall, lat, rd, wr, wAddr, wDat, tmo);
    testsRun++; if (fHit !== 1'b0 || fStall !== 1'b1) begin testsFailed++; $display("[TB] FAIL inv_next_miss: got hit=%b stall=%b want 0 1", fHit, fStall); end
    testsRun++; if (rd !== memModel[16'h1234 >> 1]) begin testsFailed++; $display("[TB] FAIL inv_refill_data: got %h want %h", rd, memModel[16'h1234 >> 1]); end
    cpu_access(1'b0, 16'h0010, 16'h0, fHit, fStall, lat, rd, wr, wAddr, wDat, tmo);
    testsRun++; if (fHit !== 1'b0) begin testsFailed++; $display("[TB] FAIL inv_other_line: got %b want 0", fHit); end
    markResident(16'h1234);
    markResident(16'h0010);
  endtask

  task automatic test_reset_mid_fill();
    logic fHit, fStall, wr, tmo;
    logic [15:0] rd, wAddr, wDat, a;
    int lat, base, n;
    base = respCount;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 16'h2468; inv_all = 1'b0;
    n = 0;
    while (respCount < base + 3 && n < 100) begin @(negedge clk); n++; end
    testsRun++; if (n >= 100) begin testsFailed++; $display("[TB] FAIL rstfill_wait: got %0d responses want 3", respCount - base); end
    rst_n = 1'b0; req = 1'b0;
    #1;
    testsRun++; if (stall !== 1'b0 || mem_rd !== 1'b0 || hit !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstfill_outputs: got stall=%b rd=%b hit=%b want 0 0 0", stall, mem_rd, hit); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clearModel();
    n = 0;
    while ((respQ.size() > 0 || mem_rvalid === 1'b1) && n < 50) begin @(negedge clk); #3; n++; end
    testsRun++; if (n >= 50) begin testsFailed++; $display("[TB] FAIL rstfill_drain: got %0d pending want 0", respQ.size()); end
    cpu_access(1'b0, 16'h2468, 16'h0, fHit, fStall, lat, rd, wr, wAddr, wDat, tmo);
    testsRun++; if (fHit !== 1'b0 || fStall !== 1'b1) begin testsFailed++; $display("[TB] FAIL rstfill_remiss: got hit=%b stall=%b want 0 1", fHit, fStall); end
    for (int i = 0; i < 8; i++) begin
      a = 16'h2460 + 16'(2 * i);
      cpu_access(1'b0, a, 16'h0, fHit, fStall, lat, rd, wr, wAddr, wDat, tmo);
      testsRun++; if (fHit !== 1'b1 || rd !== memModel[a[15:1]]) begin testsFailed++; $display("[TB] FAIL rstfill_word%0d: got hit=%b data=%h want 1 %h", i, fHit, rd, memModel[a[15:1]]); end
    end
    cpu_access(1'b0, 16'h1234, 16'h0, fHit, fStall, lat, rd, wr, wAddr, wDat, tmo);
    testsRun++; if (fHit !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstfill_old_line: got %b want 0", fHit); end
    markResident(16'h2468);
    markResident(16'h1234);
  endtask

  task automatic test_random();
    logic fHit, fStall, wr, tmo, w, expHit;
    logic [15:0] rd, wAddr, wDat, a, d;
    int lat;
    for (int op = 0; op < 150; op++) begin
      if (op == 0 || $urandom_range(15, 0) == 0) begin
        @(negedge clk); inv_all = 1'b1; req = 1'b0;
        @(negedge clk); inv_all = 1'b0;
        clearModel();
      end
      a = {5'($urandom_range(3, 0)), 7'($urandom_range(3, 0)), 3'($urandom), 1'b0};
      w = 1'($urandom);
      d = 16'($urandom);
      expHit = expValid[idxOf(a)] && (expTag[idxOf(a)] == tagOf(a));
      cpu_access(w, a, d, fHit, fStall, lat, rd, wr, wAddr, wDat, tmo);
      testsRun++; if (tmo !== 1'b0) begin testsFailed++; $display("[TB] FAIL rnd%0d_timeout: got %b want 0", op, tmo); end
      testsRun++; if (fHit !== expHit || fStall !== !expHit) begin testsFailed++; $display("[TB] FAIL rnd%0d_hit: addr=%h got hit=%b stall=%b want hit=%b", op, a, fHit, fStall, expHit); end
      if (w) begin
        testsRun++; if (wr !== 1'b1 || wAddr !== a || wDat !== d) begin testsFailed++; $display("[TB] FAIL rnd%0d_write: got wr=%b addr=%h data=%h want 1 %h %h", op, wr, wAddr, wDat, a, d); end
        memModel[a[15:1]] = d;
      end else begin
        testsRun++; if (wr !== 1'b0 || rd !== memModel[a[15:1]]) begin testsFailed++; $display("[TB] FAIL rnd%0d_read: addr=%h got wr=%b data=%h want 0 %h", op, a, wr, rd, memModel[a[15:1]]); end
      end
      markResident(a);
    end
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = 16'h0; wdata = 16'h0; inv_all = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = 16'h0;
    for (int i = 0; i < 32768; i++) memModel[i] = 16'($urandom);
    clearModel();
    test_reset();
    test_read_miss();
    test_write_hit();
    test_back_to_back();
    test_write_miss();
    test_conflict();
    test_inv_all();
    test_reset_mid_fill();
    test_random();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
